// File: rtl/piso_tx_pkg.sv
// Shared definitions for the framed serial transmitter and its matching
// receiver: FSM state encoding, line levels and a counter-width helper.
package piso_tx_pkg;

  // FSM state encoding, shared with the receiver so debug views line up.
  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_START = 2'd1;
  localparam state_t ST_DATA  = 2'd2;
  localparam state_t ST_STOP  = 2'd3;

  // Line levels used to frame a word.
  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  // Width of a counter that must hold 0..n-1; never narrower than one bit
  // so n=1 still produces a legal vector.
  function automatic int cnt_w(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/piso_serial_tx_bit_tick_gen.sv
// Bit-period timer. Counts 0..CLKS_PER_BIT-1 and wraps; tick is high on the
// last clock of every bit period. restart forces the count back to zero so
// the first period after a word is accepted lines up with the start bit.
module bit_tick_gen
  import piso_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4   // legal range 1..65535
) (
  input  logic CLK,
  input  logic CLR,
  input  logic restart,
  output logic tick
);

  localparam int CW = cnt_w(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // With CLKS_PER_BIT=1, LAST is 0 and the counter sits at 0: tick every cycle.
  assign tick = (cnt_q == LAST);

  // Next count: restart has priority, otherwise wrap at the end of a period.
  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register with synchronous clear.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/piso_serial_tx.sv
// Parallel-in serial-out framed transmitter.
//
// Handshake: a word is accepted on any rising edge where LOAD=1 and READY=1
// (READY is simply "FSM in IDLE"). LOAD while READY=0 is dropped, nothing is
// queued. DIN is only sampled on the accept edge. CLR overrides everything,
// including a simultaneous LOAD.
//
// Frame on SOUT: start bit (0), WIDTH data bits LSB first, stop bit (1), each
// held for CLKS_PER_BIT clocks. DONE pulses for one cycle in IDLE after a
// frame completes; an aborted frame (CLR) produces no DONE.
module piso_serial_tx
  import piso_tx_pkg::*;
#(
  parameter int WIDTH        = 8,  // legal range 1..32
  parameter int CLKS_PER_BIT = 4   // legal range 1..65535
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic [WIDTH-1:0] DIN,
  input  logic             LOAD,
  output logic             READY,
  output logic             SOUT,
  output logic             BUSY,
  output logic             DONE,
  output logic [1:0]       DBG_STATE
);

  localparam int BW = cnt_w(WIDTH);
  localparam logic [BW-1:0] LAST_IDX = BW'(WIDTH - 1);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;
  logic [BW-1:0]    bit_idx_q;
  logic [BW-1:0]    bit_idx_d;
  logic             done_q;
  logic             done_d;

  logic             accept;
  logic             tick;

  // Only IDLE can take a word; CLR priority is handled in the registers.
  assign accept = LOAD && (state_q == ST_IDLE);

  bit_tick_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_tick (
    .CLK     (CLK),
    .CLR     (CLR),
    .restart (accept),
    .tick    (tick)
  );

  // FSM state register with synchronous clear.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: each framing state lasts until the bit period ends.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_START;
      end
      ST_START: begin
        if (tick) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (tick && (bit_idx_q == LAST_IDX)) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (tick) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs, decoded purely from registered state.
  always_comb begin
    SOUT  = IDLE_LEVEL;
    BUSY  = 1'b0;
    READY = 1'b1;
    case (state_q)
      ST_IDLE: begin
        SOUT  = IDLE_LEVEL;
        BUSY  = 1'b0;
        READY = 1'b1;
      end
      ST_START: begin
        SOUT  = START_BIT;
        BUSY  = 1'b1;
        READY = 1'b0;
      end
      ST_DATA: begin
        SOUT  = shreg_q[0];
        BUSY  = 1'b1;
        READY = 1'b0;
      end
      ST_STOP: begin
        SOUT  = STOP_BIT;
        BUSY  = 1'b1;
        READY = 1'b0;
      end
      default: begin
        SOUT  = IDLE_LEVEL;
        BUSY  = 1'b0;
        READY = 1'b1;
      end
    endcase
  end

  assign DONE      = done_q;
  assign DBG_STATE = state_q;

  // Datapath next values: load on accept, shift and count at each data bit
  // end, and raise DONE for the cycle that follows the stop bit.
  always_comb begin
    shreg_d   = shreg_q;
    bit_idx_d = bit_idx_q;
    done_d    = 1'b0;
    if (accept) begin
      shreg_d   = DIN;
      bit_idx_d = '0;
    end else if ((state_q == ST_DATA) && tick) begin
      shreg_d = shreg_q >> 1;
      // bit_idx wraps after the last data bit rather than reaching WIDTH.
      if (bit_idx_q == LAST_IDX) begin
        bit_idx_d = '0;
      end else begin
        bit_idx_d = bit_idx_q + BW'(1);
      end
    end
    if ((state_q == ST_STOP) && tick) begin
      done_d = 1'b1;
    end
  end

  // Datapath registers; CLR aborts any frame and clears everything.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      shreg_q   <= '0;
      bit_idx_q <= '0;
      done_q    <= 1'b0;
    end else begin
      shreg_q   <= shreg_d;
      bit_idx_q <= bit_idx_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_piso_serial_tx.sv
// Directed bench for piso_serial_tx. Three instances cover the default
// configuration (WIDTH=8, CLKS_PER_BIT=4), the 1-bit/1-clock corner and a
// 32-bit word. Inputs change and outputs are sampled on the falling edge.
module tb_piso_serial_tx;
  import piso_tx_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic clr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        load8, ready8, sout8, busy8, done8;
  logic [7:0]  din8;
  logic [1:0]  st8;

  logic        load1, ready1, sout1, busy1, done1;
  logic [0:0]  din1;
  logic [1:0]  st1;

  logic        load32, ready32, sout32, busy32, done32;
  logic [31:0] din32;
  logic [1:0]  st32;

  piso_serial_tx #(.WIDTH(8), .CLKS_PER_BIT(4)) dut8 (
    .CLK(clk), .CLR(clr), .DIN(din8), .LOAD(load8), .READY(ready8),
    .SOUT(sout8), .BUSY(busy8), .DONE(done8), .DBG_STATE(st8)
  );

  piso_serial_tx #(.WIDTH(1), .CLKS_PER_BIT(1)) dut1 (
    .CLK(clk), .CLR(clr), .DIN(din1), .LOAD(load1), .READY(ready1),
    .SOUT(sout1), .BUSY(busy1), .DONE(done1), .DBG_STATE(st1)
  );

  piso_serial_tx #(.WIDTH(32), .CLKS_PER_BIT(2)) dut32 (
    .CLK(clk), .CLR(clr), .DIN(din32), .LOAD(load32), .READY(ready32),
    .SOUT(sout32), .BUSY(busy32), .DONE(done32), .DBG_STATE(st32)
  );

  // ---------------- scoreboard ----------------
  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_total++;
    assert (o === e) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  // Observed output selector: what 0=SOUT 1=BUSY 2=READY 3=DONE 4=state.
  function automatic logic [31:0] obs(input int sel, input int what);
    logic [4:0] v;
    case (sel)
      0:       v = {st8[0] ^ st8[1] ? 1'b0 : 1'b0, done8, ready8, busy8, sout8};
      1:       v = {1'b0, done1, ready1, busy1, sout1};
      default: v = {1'b0, done32, ready32, busy32, sout32};
    endcase
    if (what == 4) begin
      case (sel)
        0:       return {30'd0, st8};
        1:       return {30'd0, st1};
        default: return {30'd0, st32};
      endcase
    end
    return {31'd0, v[what]};
  endfunction

  // Expected line sequence: bit k of the result is the level of bit period k.
  function automatic logic [33:0] mkframe(input logic [31:0] d, input int w);
    logic [33:0] f;
    f = '0;
    f[0] = 1'b0;
    for (int i = 0; i < w; i++) f[i+1] = d[i];
    f[w+1] = 1'b1;
    return f;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_load(input int sel, input logic v, input logic [31:0] d);
    case (sel)
      0:       begin load8  = v; din8  = d[7:0]; end
      1:       begin load1  = v; din1  = d[0:0]; end
      default: begin load32 = v; din32 = d;      end
    endcase
  endtask

  // Present a word and return just after its accept edge.
  task automatic send(input int sel, input logic [31:0] d);
    @(negedge clk);
    set_load(sel, 1'b1, d);
    @(posedge clk);
    #1;
    set_load(sel, 1'b0, d);
  endtask

  // Walk a frame cycle by cycle from the cycle after the accept edge.
  // inj_at >= 0 pulses LOAD with inj_d on that frame cycle; abort_at >= 0
  // raises CLR on that frame cycle and checks the abort instead of DONE.
  task automatic check_frame(input int sel, input logic [33:0] fr, input int nbits,
                             input int cpb, input int inj_at, input logic [31:0] inj_d,
                             input int abort_at, input string tag);
    int cyc;
    cyc = 0;
    for (int k = 0; k < nbits; k++) begin
      for (int c = 0; c < cpb; c++) begin
        @(negedge clk);
        chk($sformatf("%s_sout_b%0d_c%0d", tag, k, c), obs(sel, 0), {31'd0, fr[k]});
        chk($sformatf("%s_busy_c%0d", tag, cyc), obs(sel, 1), 32'd1);
        if (c == 0) chk($sformatf("%s_ready_b%0d", tag, k), obs(sel, 2), 32'd0);
        if (c == 0) chk($sformatf("%s_done_b%0d", tag, k), obs(sel, 3), 32'd0);
        if (cyc == inj_at) set_load(sel, 1'b1, inj_d);
        if (inj_at >= 0 && cyc == inj_at + 1) set_load(sel, 1'b0, inj_d);
        if (cyc == abort_at) begin
          clr = 1'b1;
          @(negedge clk);
          clr = 1'b0;
          chk({tag, "_abort_sout"},  obs(sel, 0), 32'd1);
          chk({tag, "_abort_ready"}, obs(sel, 2), 32'd1);
          chk({tag, "_abort_busy"},  obs(sel, 1), 32'd0);
          chk({tag, "_abort_done"},  obs(sel, 3), 32'd0);
          chk({tag, "_abort_state"}, obs(sel, 4), {30'd0, ST_IDLE});
          @(negedge clk);
          chk({tag, "_abort_done2"}, obs(sel, 3), 32'd0);
          chk({tag, "_abort_idle2"}, obs(sel, 1), 32'd0);
          return;
        end
        cyc++;
      end
    end
    @(negedge clk);
    chk({tag, "_done"},       obs(sel, 3), 32'd1);
    chk({tag, "_done_ready"}, obs(sel, 2), 32'd1);
    chk({tag, "_done_busy"},  obs(sel, 1), 32'd0);
    chk({tag, "_done_sout"},  obs(sel, 0), 32'd1);
    chk({tag, "_done_state"}, obs(sel, 4), {30'd0, ST_IDLE});
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    clr = 1'b0;
    load8 = 1'b0;  din8 = '0;
    load1 = 1'b0;  din1 = '0;
    load32 = 1'b0; din32 = '0;

    // Reset held two cycles with LOAD high: no accept, idle outputs.
    @(negedge clk);
    clr = 1'b1;
    load8 = 1'b1; din8 = 8'h5A;
    repeat (2) @(negedge clk);
    chk("rst_sout",  obs(0, 0), 32'd1);
    chk("rst_ready", obs(0, 2), 32'd1);
    chk("rst_busy",  obs(0, 1), 32'd0);
    chk("rst_done",  obs(0, 3), 32'd0);
    chk("rst_state", obs(0, 4), {30'd0, ST_IDLE});
    chk("rst_w1_sout",  obs(1, 0), 32'd1);
    chk("rst_w32_busy", obs(2, 1), 32'd0);
    clr = 1'b0;
    load8 = 1'b0;
    @(negedge clk);
    chk("rst_noaccept_busy", obs(0, 1), 32'd0);
    chk("rst_noaccept_sout", obs(0, 0), 32'd1);

    // Single A5 frame: 0,1,0,1,0,0,1,0,1,1 at 4 clocks per bit.
    send(0, 32'hA5);
    check_frame(0, 34'b11_0100_1010, 10, 4, -1, 0, -1, "a5");
    @(negedge clk);
    chk("a5_done_once", obs(0, 3), 32'd0);

    // Back-to-back with LOAD held: 00 then FF, one idle-high cycle between.
    @(negedge clk);
    load8 = 1'b1; din8 = 8'h00;
    @(posedge clk);
    #1;
    check_frame(0, mkframe(32'h00, 8), 10, 4, -1, 0, -1, "b2b0");
    din8 = 8'hFF;
    @(posedge clk);
    #1;
    load8 = 1'b0;
    check_frame(0, mkframe(32'hFF, 8), 10, 4, -1, 0, -1, "b2b1");
    @(negedge clk);
    chk("b2b_done_once", obs(0, 3), 32'd0);
    chk("b2b_idle",      obs(0, 1), 32'd0);

    // LOAD of 3C at frame cycle 10 is ignored; frame still carries A5.
    send(0, 32'hA5);
    check_frame(0, mkframe(32'hA5, 8), 10, 4, 10, 32'h3C, -1, "ign");
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("ign_nofollow_busy%0d", i), obs(0, 1), 32'd0);
      chk($sformatf("ign_nofollow_sout%0d", i), obs(0, 0), 32'd1);
    end

    // CLR at frame cycle 17 aborts; then 81 goes out whole.
    send(0, 32'hC3);
    check_frame(0, mkframe(32'hC3, 8), 10, 4, -1, 0, 17, "abt");
    send(0, 32'h81);
    check_frame(0, 34'b11_0000_0010, 10, 4, -1, 0, -1, "x81");

    // WIDTH=1, CLKS_PER_BIT=1, DIN=1: 0,1,1 then DONE.
    send(1, 32'h1);
    check_frame(1, 34'b110, 3, 1, -1, 0, -1, "w1");
    @(negedge clk);
    chk("w1_done_once", obs(1, 3), 32'd0);

    // WIDTH=32: bit 0 right after start, MSB last before the stop bit.
    send(2, 32'h8000_0001);
    check_frame(2, {1'b1, 32'h8000_0001, 1'b0}, 34, 2, -1, 0, -1, "w32");
    @(negedge clk);
    chk("w32_done_once", obs(2, 3), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Overall time bound.
  initial begin
    #200000;
    $display("FAIL timeout: observed no end of sequence, expected completion");
    $fatal(1, "timeout");
  end

endmodule
